// File: rtl/amux_scan_seq.sv
// Scan sequencer for a 4-input analog mux and ADC: settles each enabled channel,
// triggers one conversion and keeps the last result per channel for readback.
module amux_scan_seq #(
  parameter int ADC_BITS       = 10,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                continuous,
  input  logic [3:0]          ch_mask,
  output logic [1:0]          sel,
  output logic                adc_start,
  input  logic                adc_done,
  input  logic [ADC_BITS-1:0] adc_data,
  input  logic [1:0]          rd_ch,
  output logic [ADC_BITS-1:0] rd_data,
  output logic [3:0]          valid,
  output logic                busy,
  output logic                scan_done,
  output logic                timeout_err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETTLE  = 3'd1;
  localparam logic [2:0] CONVERT = 3'd2;
  localparam logic [2:0] WAIT    = 3'd3;
  localparam logic [2:0] STORE   = 3'd4;

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]          state;
  logic [1:0]          ch;
  logic [SW-1:0]       scnt;
  logic [TW-1:0]       tcnt;
  logic                stop_pend;
  logic                conv_ok;
  logic [ADC_BITS-1:0] data_q;
  logic [ADC_BITS-1:0] result [4];

  logic [1:0] first_ch;
  logic [1:0] next_ch;
  logic       has_next;

  function automatic logic [1:0] lowest(input logic [3:0] m);
    lowest = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      if (m[i-1]) lowest = 2'(i - 1);
    end
  endfunction

  always_comb begin
    first_ch = lowest(ch_mask);
    next_ch  = ch;
    has_next = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!has_next && (i > 32'(ch)) && ch_mask[i]) begin
        has_next = 1'b1;
        next_ch  = 2'(i);
      end
    end
  end

  assign adc_start = (state == CONVERT);
  assign busy      = (state != IDLE);
  assign rd_data   = result[rd_ch];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ch          <= '0;
      sel         <= '0;
      scnt        <= '0;
      tcnt        <= '0;
      stop_pend   <= 1'b0;
      conv_ok     <= 1'b0;
      data_q      <= '0;
      valid       <= '0;
      scan_done   <= 1'b0;
      timeout_err <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) result[i] <= '0;
    end else begin
      scan_done <= 1'b0;
      // Stop is only remembered while scanning; STORE below consumes and clears it.
      if (state != IDLE && stop) stop_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (start && ch_mask != '0) begin
            valid       <= '0;
            timeout_err <= 1'b0;
            stop_pend   <= 1'b0;
            ch          <= first_ch;
            sel         <= first_ch;
            scnt        <= '0;
            state       <= SETTLE;
          end
        end
        SETTLE: begin
          if (scnt == SETTLE_LAST) state <= CONVERT;
          else scnt <= scnt + 1'b1;
        end
        CONVERT: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (adc_done) begin
            data_q  <= adc_data;
            conv_ok <= 1'b1;
            state   <= STORE;
          end else if (tcnt == TIMEOUT_LAST) begin
            timeout_err <= 1'b1;
            conv_ok     <= 1'b0;
            state       <= STORE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        STORE: begin
          if (conv_ok) begin
            result[ch] <= data_q;
            valid[ch]  <= 1'b1;
          end
          scnt <= '0;
          if (stop_pend || stop) begin
            stop_pend <= 1'b0;
            state     <= IDLE;
          end else if (has_next) begin
            ch    <= next_ch;
            sel   <= next_ch;
            state <= SETTLE;
          end else begin
            scan_done <= 1'b1;
            // Restart clears valid after the write above, so a new scan starts empty.
            if (continuous && ch_mask != '0) begin
              valid <= '0;
              ch    <= first_ch;
              sel   <= first_ch;
              state <= SETTLE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_amux_scan_seq.sv
// Scoreboard bench for amux_scan_seq: directed scans with a simple ADC responder;
// a monitor checks each conversion select and each scan_done against queued expectations.
module tb_amux_scan_seq;

  localparam int ADC_BITS = 10;
  localparam int SETTLE   = 16;
  localparam int TIMEOUT  = 255;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic                stop = 1'b0;
  logic                continuous = 1'b0;
  logic [3:0]          ch_mask = '0;
  logic [1:0]          sel;
  logic                adc_start;
  logic                adc_done = 1'b0;
  logic [ADC_BITS-1:0] adc_data = '0;
  logic [1:0]          rd_ch = '0;
  logic [ADC_BITS-1:0] rd_data;
  logic [3:0]          valid;
  logic                busy;
  logic                scan_done;
  logic                timeout_err;

  amux_scan_seq #(.ADC_BITS(ADC_BITS), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .continuous(continuous),
    .ch_mask(ch_mask), .sel(sel), .adc_start(adc_start), .adc_done(adc_done),
    .adc_data(adc_data), .rd_ch(rd_ch), .rd_data(rd_data), .valid(valid),
    .busy(busy), .scan_done(scan_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_start  = 0;
  int n_done   = 0;
  logic adc_en = 1'b1;

  int         exp_sel[$];
  logic [3:0] exp_valid[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    logic [1:0] prev_sel;
    int stable;
    prev_sel = '0;
    stable   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!busy || sel != prev_sel) stable = 0;
      if (adc_start) begin
        n_start++;
        if (exp_sel.size() == 0) chk("unexpected_adc_start", 32'(sel), 32'hdead);
        else chk("conv_sel", 32'(sel), 32'(exp_sel.pop_front()));
        chk("settle_len", stable, SETTLE);
      end else if (busy) begin
        stable++;
      end
      if (scan_done) begin
        n_done++;
        if (exp_valid.size() == 0) chk("unexpected_scan_done", 32'(valid), 32'hdead);
        else chk("done_valid", 32'(valid), 32'(exp_valid.pop_front()));
      end
      prev_sel = sel;
    end
  end

  // ADC responder: result 10'h100 + channel, five cycles after the trigger.
  initial begin
    logic [1:0] s;
    forever begin
      @(posedge clk);
      #1;
      if (adc_start && adc_en) begin
        s = sel;
        repeat (4) @(posedge clk);
        @(negedge clk);
        adc_done = 1'b1;
        adc_data = 10'h100 + {8'd0, s};
        @(negedge clk);
        adc_done = 1'b0;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    while (busy && k < lim) begin
      tick(1);
      k++;
    end
    chk("wait_idle", 32'(busy), 0);
  endtask

  task automatic rd(input logic [1:0] c, input logic [ADC_BITS-1:0] exp, input string nm);
    @(negedge clk) rd_ch = c;
    #1 chk(nm, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    int base, k;
    tick(3);
    @(negedge clk) reset = 1'b0;
    tick(1);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_adc_start", 32'(adc_start), 0);
    chk("rst_scan_done", 32'(scan_done), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    chk("rst_valid", 32'(valid), 0);
    rd(2'd0, '0, "rst_rd0");

    // Full scan, with an ignored start while busy.
    base = n_start;
    ch_mask = 4'b1111;
    exp_sel.push_back(0); exp_sel.push_back(1); exp_sel.push_back(2); exp_sel.push_back(3);
    exp_valid.push_back(4'b1111);
    pulse_start();
    chk("busy_after_start", 32'(busy), 1);
    tick(40);
    pulse_start();
    wait_idle(2000);
    chk("full_nstart", n_start - base, 4);
    chk("full_valid", 32'(valid), 4'b1111);
    chk("full_sel_hold", 32'(sel), 3);
    chk("full_timeout", 32'(timeout_err), 0);
    rd(2'd2, 10'h102, "full_rd2");
    rd(2'd3, 10'h103, "full_rd3");
    chk("full_selq_empty", exp_sel.size(), 0);
    chk("full_doneq_empty", exp_valid.size(), 0);

    // Sparse mask.
    base = n_start;
    ch_mask = 4'b1010;
    exp_sel.push_back(1); exp_sel.push_back(3);
    exp_valid.push_back(4'b1010);
    pulse_start();
    wait_idle(1000);
    chk("sparse_nstart", n_start - base, 2);
    chk("sparse_valid", 32'(valid), 4'b1010);
    rd(2'd1, 10'h101, "sparse_rd1");
    rd(2'd2, 10'h102, "sparse_rd2_stale");

    // Timeout: ADC silent.
    adc_en = 1'b0;
    ch_mask = 4'b0001;
    exp_sel.push_back(0);
    exp_valid.push_back(4'b0000);
    pulse_start();
    wait_idle(SETTLE + TIMEOUT + 20);
    chk("to_err", 32'(timeout_err), 1);
    chk("to_valid", 32'(valid), 0);
    adc_en = 1'b1;
    exp_sel.push_back(0);
    exp_valid.push_back(4'b0001);
    pulse_start();
    chk("to_cleared", 32'(timeout_err), 0);
    wait_idle(1000);
    chk("to_retry_valid", 32'(valid), 4'b0001);

    // Start with empty mask is ignored.
    base = n_start;
    ch_mask = 4'b0000;
    pulse_start();
    tick(5);
    chk("zmask_busy", 32'(busy), 0);
    chk("zmask_nstart", n_start - base, 0);

    // Continuous scan, stopped during second-scan ch1 settle.
    continuous = 1'b1;
    ch_mask = 4'b0011;
    base = n_done;
    exp_sel.push_back(0); exp_sel.push_back(1); exp_sel.push_back(0); exp_sel.push_back(1);
    exp_valid.push_back(4'b0000);
    pulse_start();
    k = 0;
    while (n_done == base && k < 1000) begin tick(1); k++; end
    chk("cont_first_done", n_done - base, 1);
    k = 0;
    while (sel != 2'd1 && k < 1000) begin tick(1); k++; end
    chk("cont_reach_ch1", 32'(sel), 1);
    pulse_stop();
    wait_idle(1000);
    continuous = 1'b0;
    tick(100);
    chk("cont_ndone", n_done - base, 1);
    chk("cont_valid", 32'(valid), 4'b0011);
    rd(2'd1, 10'h101, "cont_rd1");
    chk("cont_selq_empty", exp_sel.size(), 0);

    // Reset during WAIT; the late adc_done must be ignored.
    ch_mask = 4'b0001;
    base = n_start;
    exp_sel.push_back(0);
    pulse_start();
    k = 0;
    while (n_start == base && k < 200) begin tick(1); k++; end
    chk("rstw_conv_seen", n_start - base, 1);
    @(negedge clk) reset = 1'b1;
    tick(1);
    chk("rstw_busy", 32'(busy), 0);
    chk("rstw_adc_start", 32'(adc_start), 0);
    chk("rstw_valid", 32'(valid), 0);
    chk("rstw_sel", 32'(sel), 0);
    rd(2'd0, '0, "rstw_rd0");
    @(negedge clk) reset = 1'b0;
    tick(10);
    chk("rstw_busy_after", 32'(busy), 0);
    chk("rstw_valid_after", 32'(valid), 0);
    rd(2'd0, '0, "rstw_rd0_after");
    chk("final_selq_empty", exp_sel.size(), 0);
    chk("final_doneq_empty", exp_valid.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/amux_scan_seq.md
Name: amux_scan_seq

Overview:
- Digital controller that drives the 2-bit select of the 4-input analog multiplexer.
- Sequences through the enabled channels. Per channel: hold the select, wait a settling interval, trigger one ADC conversion, capture the result.
- Stores the last result per channel for software readback.
- Sits between the housekeeping register bank and the analog mux/ADC pair, in the 1.8V digital domain.

Parameters:
ADC_BITS, 10, width of ADC result
SETTLE_CYCLES, 16, clk cycles sel is held stable before conversion start (min 1)
TIMEOUT_CYCLES, 255, max clk cycles waiting for adc_done before abort (min 1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
start  input  1  one-cycle pulse: begin a scan
stop  input  1  one-cycle pulse: abort after current channel
continuous  input  1  1 = restart scan automatically after last channel
ch_mask  input  4  channel enables, bit n = mux input n+1
sel  output  2  mux select to analog mux
adc_start  output  1  one-cycle conversion trigger
adc_done  input  1  one-cycle pulse: adc_data valid
adc_data  input  ADC_BITS  conversion result
rd_ch  input  2  readback channel index
rd_data  output  ADC_BITS  stored result of channel rd_ch (combinational read)
valid  output  4  bit n set when channel n holds a result from the current/last scan
busy  output  1  high outside IDLE
scan_done  output  1  one-cycle pulse at end of each full scan
timeout_err  output  1  sticky; set on ADC timeout, cleared by start or reset

Behaviour:
- Reset (sync, dominates all inputs) yields:
  - state IDLE
  - sel=0, adc_start=0, busy=0, scan_done=0, timeout_err=0
  - valid=0, all result registers 0, counters 0
- Interface: one clock; reset is synchronous and active-high.
- States: IDLE, SETTLE, CONVERT, WAIT, STORE.
- IDLE:
  - start with ch_mask!=0: clear valid and timeout_err, load ch = lowest set bit of ch_mask, drive sel=ch, go SETTLE.
  - start with ch_mask==0: ignored; no state change, no pulse.
- SETTLE:
  - sel already updated on entry.
  - Counter counts SETTLE_CYCLES cycles, then go CONVERT.
  - sel is stable for exactly SETTLE_CYCLES cycles before adc_start.
- CONVERT: adc_start=1 for exactly one cycle; go WAIT with timeout counter cleared.
- WAIT:
  - adc_done=1: latch adc_data, go STORE.
  - TIMEOUT_CYCLES elapsed without adc_done: set timeout_err, channel not stored, go STORE path without write.
  - adc_done arriving in any other state is ignored.
- STORE:
  - On a successful conversion, write result[ch] and set valid[ch].
  - Next channel = next set bit of ch_mask above ch; ch_mask is sampled here, so live changes apply from the next channel.
  - If one exists: sel=next, go SETTLE.
  - Otherwise end of scan: pulse scan_done.
    - If continuous=1 and no stop pending: clear valid, restart at lowest set bit (re-sampled mask) in SETTLE.
    - Else go IDLE.
- stop:
  - Latched as a pending flag in any non-IDLE state.
  - Honoured at the next STORE: the current result is stored, then the block goes IDLE without scan_done.
  - Ignored in IDLE. start while busy is ignored.
- Mask becoming 0 during a scan: scan ends at next STORE with scan_done, go IDLE.
- Simultaneous start and stop in IDLE: start wins; stop is ignored.
- sel is held at the last channel in IDLE; it changes only on entry to SETTLE.
- Counters saturate-free: widths sized by $clog2 of each parameter, compared with ==.
- rd_data = result[rd_ch], no latency; returns stale data for channels with valid=0.
- Reset asserted mid-scan: block returns to reset values on the next edge; no adc_start is issued that cycle.

Test Plan:
- ch_mask=4'b1111, continuous=0, start pulse; ADC model answers 5 cycles after adc_start with data 10'h100+ch:
  - sel steps 0,1,2,3, each held SETTLE_CYCLES=16 cycles before adc_start.
  - Exactly 4 adc_start pulses, scan_done once, valid=4'b1111.
  - rd_ch=2 gives rd_data=10'h102. busy returns 0.
- ch_mask=4'b1010, start:
  - Only sel=1 and sel=3 are visited.
  - valid=4'b1010, scan_done after 2 conversions.
- ch_mask=4'b0001, ADC never responds:
  - After CONVERT + 255 cycles, timeout_err=1, valid=0, scan_done pulses, IDLE.
  - Next start clears timeout_err.
- continuous=1, ch_mask=4'b0011:
  - scan_done pulses every scan.
  - stop asserted in SETTLE of ch1: ch1 is stored, IDLE, no further scan_done.
- Reset asserted during WAIT: all outputs at reset values next cycle; an adc_done pulse the following cycle does not change results.
- start with ch_mask=0, and a second start during busy: both ignored; busy stays 0 and 1 respectively, no extra adc_start.
